fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Fetch unit side: issues requests, receives acceptance and read data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, 2-entry {instr, addr}
// buffer feeding decode, flush support with late-response discard.
module fetch_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc,
    input  logic         flush,
    output logic         pc_stall,
    fetch_unit_if.master bus,
    output logic         ir_valid,
    output logic [31:0]  ir,
    output logic [31:0]  ir_pc,
    input  logic         dec_ready
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_next;
    logic [1:0]  count, count_next;
    logic        discard, discard_next;
    logic [31:0] pending_addr;
    logic        wr_ptr, rd_ptr;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_addr  [2];

    logic req, accept, push, pop;

    // Head of the buffer drives decode directly.
    assign ir_valid = (count != 2'd0);
    assign ir       = fifo_instr[rd_ptr];
    assign ir_pc    = fifo_addr[rd_ptr];

    assign bus.imem_req  = req;
    assign bus.imem_addr = req ? pc : 32'h0;

    // Request issue, PC stall and buffer update strobes.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        req      = 1'b0;
        pc_stall = 1'b1;
        // The space rule (count<2) guarantees the outstanding response always fits.
        // During flush the incoming pc is stale, so no request is issued.
        if (reset && !flush && state == REQ && !count[1])
            req = 1'b1;
        accept = req && bus.imem_ready;
        if (reset)
            pc_stall = !(flush || accept);
        push = (state == WAIT) && bus.imem_rvalid && !discard && !flush;
        pop  = ir_valid && dec_ready && !flush;
    end

    // Next state, next occupancy and discard tracking.
    always_comb begin
        state_next   = state;
        discard_next = discard;
        count_next   = count + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            count_next = 2'd0;
            // A response arriving in the flush cycle is dropped outright; only a
            // still-outstanding request needs the discard flag to catch it later.
            if (state == WAIT && !bus.imem_rvalid) begin
                state_next   = WAIT;
                discard_next = 1'b1;
            end else begin
                state_next   = REQ;
                discard_next = 1'b0;
            end
        end else begin
            case (state)
                REQ:  if (accept) state_next = WAIT;
                WAIT: if (bus.imem_rvalid) begin
                          discard_next = 1'b0;
                          state_next   = count_next[1] ? HOLD : REQ;
                      end
                HOLD: if (!count[1]) state_next = REQ;
                default: state_next = REQ;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state        <= REQ;
            count        <= 2'd0;
            discard      <= 1'b0;
            pending_addr <= 32'h0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            discard <= discard_next;
            if (accept)
                pending_addr <= pc;
        end
    end

    // Buffer storage and pointers; flush only rewinds the pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            // NOTE: the two entries are reset because ir/ir_pc must read zero while reset is held.
            for (int i = 0; i < 2; i++) begin
                fifo_instr[i] <= 32'h0;
                fifo_addr[i]  <= 32'h0;
            end
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= bus.imem_rdata;
                fifo_addr[wr_ptr]  <= pending_addr;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic        pc_stall;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        dec_ready;
    bit          mem_auto;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .flush     (flush),
        .pc_stall  (pc_stall),
        .bus       (bus.master),
        .ir_valid  (ir_valid),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .dec_ready (dec_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_fetch(input string tag, input logic req, input logic [31:0] addr, input logic stall);
        check({tag, ".req"}, 32'(bus.imem_req), 32'(req));
        if (req)
            check({tag, ".addr"}, bus.imem_addr, addr);
        check({tag, ".stall"}, 32'(pc_stall), 32'(stall));
    endtask

    task automatic expect_ir(input string tag, input logic valid, input logic [31:0] addr);
        check({tag, ".valid"}, 32'(ir_valid), 32'(valid));
        if (valid) begin
            check({tag, ".ir_pc"}, ir_pc, addr);
            check({tag, ".ir"}, ir, instr_of(addr));
        end
    endtask

    task automatic expect_reset_outputs(input string tag);
        check({tag, ".req"},   32'(bus.imem_req), 32'd0);
        check({tag, ".addr"},  bus.imem_addr, 32'd0);
        check({tag, ".valid"}, 32'(ir_valid), 32'd0);
        check({tag, ".ir"},    ir, 32'd0);
        check({tag, ".ir_pc"}, ir_pc, 32'd0);
        check({tag, ".stall"}, 32'(pc_stall), 32'd1);
    endtask

    // One clock: memory answers a request accepted this cycle on the next cycle.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        acc = bus.imem_req && bus.imem_ready;
        a   = bus.imem_addr;
        @(posedge clk);
        #1;
        if (mem_auto && acc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = instr_of(a);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
    endtask

    initial begin
        reset = 1'b0; pc = 32'h1234; flush = 1'b1; dec_ready = 1'b0; mem_auto = 1'b0;
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        #2;
        expect_reset_outputs("reset");

        // Streaming: request, response, consume.
        @(posedge clk); #1;
        reset = 1'b1; flush = 1'b0; pc = 32'h0; dec_ready = 1'b1; mem_auto = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            expect_fetch("stream_req", 1'b1, 32'(k), 1'b0);
            if (k > 0)
                expect_ir("stream_head", 1'b1, 32'(k - 1));
            cyc(); pc = 32'(k + 1); #1;
            expect_fetch("stream_wait", 1'b0, 32'h0, 1'b1);
            expect_ir("stream_wait_ir", 1'b0, 32'h0);
            cyc(); #1;
        end

        // Backpressure: fill to two, hold, drain in order.
        dec_ready = 1'b0;
        expect_fetch("bp_req", 1'b1, 32'h4, 1'b0);
        expect_ir("bp_head", 1'b1, 32'h3);
        cyc(); pc = 32'h5; #1;
        expect_fetch("bp_wait", 1'b0, 32'h0, 1'b1);
        cyc(); #1;
        expect_fetch("bp_hold", 1'b0, 32'h0, 1'b1);
        expect_ir("bp_hold_ir", 1'b1, 32'h3);
        cyc(); #1;
        expect_fetch("bp_hold2", 1'b0, 32'h0, 1'b1);
        expect_ir("bp_hold2_ir", 1'b1, 32'h3);
        dec_ready = 1'b1;
        cyc(); #1;
        expect_fetch("bp_drain", 1'b0, 32'h0, 1'b1);
        expect_ir("bp_drain_ir", 1'b1, 32'h4);
        cyc(); #1;
        expect_ir("bp_empty", 1'b0, 32'h0);

        // Flush while request for addr 5 is outstanding; late response dropped.
        expect_fetch("flw_req", 1'b1, 32'h5, 1'b0);
        mem_auto = 1'b0;
        cyc(); pc = 32'h40; flush = 1'b1; #1;
        expect_fetch("flw_flush", 1'b0, 32'h0, 1'b0);
        expect_ir("flw_flush_ir", 1'b0, 32'h0);
        cyc(); flush = 1'b0; #1;
        expect_fetch("flw_wait", 1'b0, 32'h0, 1'b1);
        cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = instr_of(32'h5); #1;
        expect_fetch("flw_resp", 1'b0, 32'h0, 1'b1);
        expect_ir("flw_resp_ir", 1'b0, 32'h0);
        cyc(); #1;
        expect_ir("flw_dropped", 1'b0, 32'h0);
        expect_fetch("flw_target", 1'b1, 32'h40, 1'b0);

        // Flush coincident with the response.
        mem_auto = 1'b1;
        cyc(); flush = 1'b1; pc = 32'h80; #1;
        expect_fetch("frv_flush", 1'b0, 32'h0, 1'b0);
        expect_ir("frv_flush_ir", 1'b0, 32'h0);
        cyc(); flush = 1'b0; dec_ready = 1'b0; #1;
        expect_ir("frv_dropped", 1'b0, 32'h0);
        expect_fetch("frv_next", 1'b1, 32'h80, 1'b0);

        // Flush with a full buffer, pop requested in the same cycle.
        cyc(); pc = 32'h81; #1;
        expect_fetch("f2_wait", 1'b0, 32'h0, 1'b1);
        cyc(); #1;
        expect_ir("f2_one", 1'b1, 32'h80);
        expect_fetch("f2_req", 1'b1, 32'h81, 1'b0);
        cyc(); pc = 32'h82; #1;
        cyc(); #1;
        expect_ir("f2_full", 1'b1, 32'h80);
        expect_fetch("f2_hold", 1'b0, 32'h0, 1'b1);
        flush = 1'b1; pc = 32'h90; dec_ready = 1'b1; #1;
        expect_fetch("f2_flush", 1'b0, 32'h0, 1'b0);
        cyc(); flush = 1'b0; #1;
        expect_ir("f2_empty", 1'b0, 32'h0);
        expect_fetch("f2_next", 1'b1, 32'h90, 1'b0);

        // Flush in REQ with space: request suppressed that cycle.
        flush = 1'b1; pc = 32'hA0; #1;
        expect_fetch("freq_flush", 1'b0, 32'h0, 1'b0);

        // Memory stall: request held, address stable, PC stalled.
        cyc(); flush = 1'b0; bus.imem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            expect_fetch("mstall", 1'b1, 32'hA0, 1'b1);
            cyc(); #1;
        end
        bus.imem_ready = 1'b1; dec_ready = 1'b0; #1;
        expect_fetch("mstall_go", 1'b1, 32'hA0, 1'b0);
        cyc(); pc = 32'hA1; #1;
        cyc(); #1;
        expect_ir("rst_setup", 1'b1, 32'hA0);
        expect_fetch("rst_setup_req", 1'b1, 32'hA1, 1'b0);

        // Reset mid-WAIT with one buffered entry: outputs clear before any edge.
        mem_auto = 1'b0;
        cyc(); #1;
        expect_ir("rst_pre", 1'b1, 32'hA0);
        reset = 1'b0; #1;
        expect_reset_outputs("rst_async");
        #1;
        reset = 1'b1; pc = 32'h200; dec_ready = 1'b1; mem_auto = 1'b1; #1;
        expect_fetch("rst_first", 1'b1, 32'h200, 1'b0);
        expect_ir("rst_first_ir", 1'b0, 32'h0);
        cyc(); pc = 32'h201; #1;
        cyc(); #1;
        expect_ir("rst_stream", 1'b1, 32'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
